rop3_feeder: RTL and testbench

ROP3_FEEDER -- requirements
Module: rop3_feeder

---
 rtl/rop3_feeder.sv | 156 +++++++++++++++
 tb/tb_rop3_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rop3_feeder.sv
// Request FIFO feeding a ROP3 stage: each queued (mode, P, S, D) request is
// serialized as three operand beats with the mode byte held alongside.
module rop3_feeder #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_mode,
  input  logic [N-1:0] in_p,
  input  logic [N-1:0] in_s,
  input  logic [N-1:0] in_d,
  output logic [N-1:0] Bitmap,
  output logic [7:0]   Mode,
  output logic [1:0]   load_sel,
  output logic         frame_done,
  output logic [15:0]  op_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 8 + 3 * N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_P = 2'd1,
    LOAD_S = 2'd2,
    LOAD_D = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;
  logic [7:0]    head_mode;
  logic [N-1:0]  head_p, head_s, head_d;

  logic [7:0]    hold_mode;
  logic [N-1:0]  hold_p, hold_s, hold_d;
  logic [N-1:0]  bitmap_nxt;
  logic [7:0]    mode_nxt;

  // in_ready comes from the registered occupancy only, so a pop can never open a slot
  // for a write in the same cycle.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  assign head      = mem[rd_ptr];
  assign head_mode = head[EW-1 -: 8];
  assign head_p    = head[3*N-1 -: N];
  assign head_s    = head[2*N-1 -: N];
  assign head_d    = head[N-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_mode, in_p, in_s, in_d};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOAD_P;
        end
      end
      LOAD_P: state_nxt = LOAD_S;
      LOAD_S: state_nxt = LOAD_D;
      LOAD_D: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOAD_P;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge as it.
  always_comb begin
    bitmap_nxt = '0;
    mode_nxt   = '0;
    case (state_nxt)
      LOAD_P: begin
        bitmap_nxt = head_p;
        mode_nxt   = head_mode;
      end
      LOAD_S: begin
        bitmap_nxt = hold_s;
        mode_nxt   = hold_mode;
      end
      LOAD_D: begin
        bitmap_nxt = hold_d;
        mode_nxt   = hold_mode;
      end
      default: begin
        bitmap_nxt = '0;
        mode_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      hold_mode  <= '0;
      hold_p     <= '0;
      hold_s     <= '0;
      hold_d     <= '0;
      Bitmap     <= '0;
      Mode       <= '0;
      frame_done <= 1'b0;
      op_count   <= '0;
    end else begin
      state      <= state_nxt;
      Bitmap     <= bitmap_nxt;
      Mode       <= mode_nxt;
      frame_done <= (state_nxt == LOAD_D);
      if (pop) begin
        hold_mode <= head_mode;
        hold_p    <= head_p;
        hold_s    <= head_s;
        hold_d    <= head_d;
      end
      if (state == LOAD_D) op_count <= op_count + 16'd1;
    end
  end

  assign load_sel = state;

endmodule

// File: tb/tb_rop3_feeder.sv
// Scoreboarded bench for rop3_feeder: each accepted request queues its three
// expected beats; a negedge monitor pops and compares whenever the DUT is busy.
module tb_rop3_feeder;
  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         srst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_mode = '0;
  logic [N-1:0] in_p = '0, in_s = '0, in_d = '0;
  logic [N-1:0] Bitmap;
  logic [7:0]   Mode;
  logic [1:0]   load_sel;
  logic         frame_done;
  logic [15:0]  op_count;

  rop3_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_p(in_p), .in_s(in_s), .in_d(in_d),
    .Bitmap(Bitmap), .Mode(Mode), .load_sel(load_sel),
    .frame_done(frame_done), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]   mode;
    logic [N-1:0] bm;
    logic [1:0]   sel;
    int           acc;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, errors = 0;
  int ops = 0, run = 0, max_run = 0, blocked = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (load_sel != 2'd0) begin
        run++;
        chk("op_count_busy", 32'(op_count), 32'(ops % 65536));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual sel=%0d bitmap=0x%0h required=no output cycle=%0d",
                   load_sel, Bitmap, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("load_sel", 32'(load_sel), 32'(e.sel));
          chk("bitmap", 32'(Bitmap), 32'(e.bm));
          chk("mode", 32'(Mode), 32'(e.mode));
          chk("frame_done", 32'(frame_done), 32'(e.sel == 2'd3));
          if (e.sel == 2'd3) ops++;
        end
      end else begin
        run = 0;
        chk("idle_bitmap", 32'(Bitmap), 32'd0);
        chk("idle_mode", 32'(Mode), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);
        chk("op_count_idle", 32'(op_count), 32'(ops % 65536));
        // A request accepted at edge k must be in LOAD_P after edge k+1.
        if (exp_q.size() != 0) chk("idle_stall", 32'(cyc >= exp_q[0].acc + 1), 32'd0);
      end
      if (run > max_run) max_run = run;
      if (srst) begin
        exp_q.delete();
        ops = 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] m, input logic [N-1:0] p, input logic [N-1:0] s,
                      input logic [N-1:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_p     = p;
    in_s     = s;
    in_d     = d;
    while (!in_ready && w < 100) begin
      blocked++;
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 required=1 within 100 cycles");
    end else begin
      exp_q.push_back('{mode: m, bm: p, sel: 2'd1, acc: cyc + 1});
      exp_q.push_back('{mode: m, bm: s, sel: 2'd2, acc: cyc + 1});
      exp_q.push_back('{mode: m, bm: d, sel: 2'd3, acc: cyc + 1});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(8'($urandom), N'($urandom), N'($urandom), N'($urandom));
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || load_sel != 2'd0) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    srst     = 1'b1;
    in_valid = 1'b1;
    in_mode  = 8'($urandom);
    in_p     = N'($urandom);
    in_s     = N'($urandom);
    in_d     = N'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    srst     = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none

    do_reset();
    chk("rst_load_sel", 32'(load_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_bitmap", 32'(Bitmap), 32'd0);
    chk("rst_mode", 32'(Mode), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // Single directed request with exact cycle timing.
    send(8'h96, 8'hF0, 8'hCC, 8'hAA);
    chk("single_t0_sel", 32'(load_sel), 32'd0);
    @(posedge clk); #1;
    chk("single_p_sel", 32'(load_sel), 32'd1);
    chk("single_p_bm", 32'(Bitmap), 32'hF0);
    chk("single_p_mode", 32'(Mode), 32'h96);
    @(posedge clk); #1;
    chk("single_s_sel", 32'(load_sel), 32'd2);
    chk("single_s_bm", 32'(Bitmap), 32'hCC);
    chk("single_s_mode", 32'(Mode), 32'h96);
    @(posedge clk); #1;
    chk("single_d_sel", 32'(load_sel), 32'd3);
    chk("single_d_bm", 32'(Bitmap), 32'hAA);
    chk("single_d_fd", 32'(frame_done), 32'd1);
    @(posedge clk); #1;
    chk("single_end_sel", 32'(load_sel), 32'd0);
    chk("single_end_bm", 32'(Bitmap), 32'd0);
    chk("single_end_mode", 32'(Mode), 32'd0);
    chk("single_op_count", 32'(op_count), 32'd1);

    // Six requests on consecutive cycles.
    do_reset();
    max_run = 0;
    for (int i = 0; i < 6; i++) send_rand();
    chk("b2b_in_ready_full", 32'(in_ready), 32'd0);
    drain();
    chk("b2b_run_len", 32'(max_run), 32'd18);
    chk("b2b_op_count", 32'(op_count), 32'd6);

    // Full FIFO with in_valid held high while blocked.
    do_reset();
    blocked = 0;
    for (int i = 0; i < 12; i++) send_rand();
    chk("full_blocked_seen", 32'(blocked != 0), 32'd1);
    drain();
    chk("full_op_count", 32'(op_count), 32'd12);

    // Reset during LOAD_S with two requests queued; a request is offered during reset.
    do_reset();
    for (int i = 0; i < 3; i++) send_rand();
    chk("midrst_pre_sel", 32'(load_sel), 32'd2);
    srst     = 1'b1;
    in_valid = 1'b1;
    in_mode  = 8'h5A;
    @(posedge clk); #1;
    srst     = 1'b0;
    in_valid = 1'b0;
    chk("midrst_sel", 32'(load_sel), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_op_count", 32'(op_count), 32'd0);
    chk("midrst_bitmap", 32'(Bitmap), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midrst_quiet_sel", 32'(load_sel), 32'd0);

    // Random requests with random gaps.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_rand();
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    chk("rand_op_count", 32'(op_count), 32'd40);

    // Run op_count up to 0xFFFF, then one more operation wraps it.
    do_reset();
    for (int i = 0; i < 65535; i++) send_rand();
    drain();
    chk("wrap_pre", 32'(op_count), 32'hFFFF);
    send_rand();
    drain();
    chk("wrap_post", 32'(op_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
